matvec_stream_tx: RTL and testbench
===================================

# matvec_stream_tx

Output-side streaming transmitter for the matrix-vector multiplier pipeline. Owns the multiplier's clock enable, tracks in-flight vectors through its fixed-latency pipeline, and captures each completed R-element result vector. It then transmits the vector element by element over a valid/ready stream with a last marker. It sits between the multiplier's parallel `y` bus and the downstream result consumer (DMA / bus-side FIFO).

## Interface
- `R`, 8: result elements per vector (rows of the multiplier).
- `W_Y`, 19: signed width of each multiplier output element.
- `LATENCY`, 4: multiplier pipeline depth in enabled cycles; 1 multiply stage plus $clog2(C) adder stages. Must be ≥ 1.
- `W_O`, 16: signed width of each transmitted element; `W_O` ≤ `W_Y`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  upstream has a new x/k operand set on the multiplier inputs.
- `s_ready`  out  1  operand accepted this cycle; equal to `mv_cen`.
- `mv_cen`  out  1  clock enable driven to the multiplier `cen`.
- `mv_y`  in  R×W_Y  packed signed multiplier results; element r is `mv_y[r]`.
- `m_data`  out  W_O  current transmitted element.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_last`  out  1  current beat is element R-1.
- `m_index`  out  $clog2(R) (min 1)  index r of the current beat.

## Operation
- Token pipeline `tok[LATENCY-1:0]`: on an edge with `mv_cen`=1, `tok <= {tok[LATENCY-2:0], s_valid}`. It holds when `mv_cen`=0.
- When `tok[LATENCY-1]`=1, `mv_y` holds a completed vector.
- The buffer FSM has two states: EMPTY and SEND.
- Stall rule: `mv_cen = !(tok[LATENCY-1] && state==SEND)`. This is combinational from registers only, with no path from `m_ready`.
- EMPTY:
  - `m_valid`=0.
  - If `tok[LATENCY-1]`=1, capture all R elements of `mv_y` into the buffer, set index to 0, and go to SEND.
- SEND:
  - `m_valid`=1, `m_data`=buffer[index] (width-converted), `m_index`=index, `m_last`=(index==R-1).
  - On `m_valid && m_ready`: if not last, increment index; if last, go to EMPTY with index 0.
  - There is no capture on the cycle the last beat is accepted. The buffer frees one cycle later, giving one bubble.
- Once `m_valid` rises, `m_data`, `m_index` and `m_last` stay stable until the handshake.
- A token at the pipeline tail while in SEND stalls the whole multiplier. Upstream then sees `s_ready`=0 and must hold its operands.
- A token vacated from the tail with `s_valid`=0 shifts in 0. Empty slots never capture.
- `R`=1: every beat is last; `m_index` is always 0.

## Timing
- Reset (`rstn`=0, asynchronous) forces:
  - `tok`=0, state EMPTY, index 0, buffer=0.
  - Outputs: `m_valid`=0, `m_data`=0, `m_last`=0, `m_index`=0, `mv_cen`=1, `s_ready`=1.
- Reset mid-transfer discards the buffered vector and all in-flight tokens. No partial vector is resumed.
- Operand accepted at edge N (`s_valid`=`mv_cen`=1):
  - `tok[LATENCY-1]` rises after edge N+LATENCY-1.
  - The vector is captured at edge N+LATENCY, with `m_valid` high from then on.
  - This assumes no stalls; each stalled cycle adds one.
- Peak throughput is one vector per R+1 cycles with `m_ready` held high. Back-to-back operands at full rate stall after the first vector.
- `m_ready` low holds the current beat indefinitely. No beat is dropped or duplicated.

## Configuration
- `MATVEC_TX_SAT_EN` defined: each element is converted from `W_Y` to `W_O` by signed saturation.
  - Above 2^(W_O-1)-1 → 2^(W_O-1)-1.
  - Below -2^(W_O-1) → -2^(W_O-1).
- Not defined: two's-complement truncation to the low `W_O` bits (wrap).
- With `W_O`==`W_Y`, both modes are pass-through.

## Test plan
- Single vector, defaults, `m_ready`=1, `mv_y`={8,7,...,1} (element r = r+1) at the tail:
  - `s_valid` pulse at edge N.
  - `m_valid` rises after edge N+4.
  - Beats 1..8 on consecutive cycles with `m_index` 0..7.
  - `m_last` only on value 8.
- Back-to-back: `s_valid` held 1 for 3 cycles, `m_ready`=1:
  - `mv_cen` drops while SEND holds vector 1.
  - 24 beats total, in order, with exactly one idle cycle between vectors.
- Backpressure: `m_ready` toggles 1,0,0,1 repeating.
  - Each beat is held stable while `m_ready`=0.
  - All 8 beats arrive once each.
  - `mv_cen` is 0 whenever a second token waits at the tail.
- Width conversion, `mv_y` element = 40000 and -40000, `W_O`=16:
  - With macro: 32767 / -32768.
  - Without macro: -25536 / 25536.
- Asynchronous reset asserted after beat 3 of 8, mid-cycle:
  - `m_valid`, `m_data`, `m_last` go 0 immediately.
  - `mv_cen`=1.
  - After release, no stale beats appear until a new `s_valid`.
- `R`=1, `LATENCY`=1: `s_valid` pulse gives a single beat with `m_last`=1 and `m_index`=0, one cycle after the acceptance edge.

Source files
------------

// File: rtl/matvec_stream_tx.sv
// Purpose: owns the multiplier clock enable, tracks in-flight vectors, buffers each result and streams it out element by element.
// Latency: vector captured LATENCY enabled edges after its operand is accepted; first beat valid from that edge.
// Backpressure: a completed vector arriving while the buffer is still sending stalls the whole multiplier (mv_cen=0, s_ready=0).
// Build option: define MATVEC_TX_SAT_EN for signed saturation to W_O bits; otherwise elements wrap (low W_O bits).
module matvec_stream_tx #(
  parameter int R       = 8,
  parameter int W_Y     = 19,
  parameter int LATENCY = 4,
  parameter int W_O     = 16,
  localparam int IW     = (R > 1) ? $clog2(R) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    mv_cen,
  input  logic [R-1:0][W_Y-1:0]   mv_y,
  output logic [W_O-1:0]          m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [IW-1:0]           m_index
);

  typedef enum logic {EMPTY, SEND} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);

  state_t               state_q;
  logic [LATENCY-1:0]   tok;
  logic                 tok_tail;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_nxt;
  logic [W_O-1:0]       data_buf [R];

`ifndef MATVEC_TX_SAT_EN
  // Wrap mode only looks at the low W_O bits of each element.
  logic unused_y;
  assign unused_y = ^mv_y;
`endif

  // Narrow one multiplier element to the transmit width.
  function automatic logic [W_O-1:0] conv(input logic [W_Y-1:0] y);
`ifdef MATVEC_TX_SAT_EN
    logic [W_Y-W_O:0] top;
    top = y[W_Y-1:W_O-1];
    if ((&top) || !(|top))
      conv = y[W_O-1:0];
    else if (y[W_Y-1])
      conv = {1'b1, {(W_O-1){1'b0}}};
    else
      conv = {1'b0, {(W_O-1){1'b1}}};
`else
    conv = y[W_O-1:0];
`endif
  endfunction

  assign tok_tail = tok[LATENCY-1];
  // Stall only when a finished vector has nowhere to go; no path from m_ready.
  assign mv_cen   = !(tok_tail && (state_q == SEND));
  assign s_ready  = mv_cen;
  assign idx_nxt  = idx_q + IW'(1);
  assign m_index  = idx_q;
  assign m_data   = m_valid ? data_buf[idx_q] : '0;

  generate
    if (LATENCY == 1) begin : g_tok1
      // Single-stage multiplier: the token is just the accepted operand flag.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       tok <= '0;
        else if (mv_cen) tok <= s_valid;
      end
    end else begin : g_tokn
      // Shift an occupancy token alongside each operand set, frozen while stalled.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       tok <= '0;
        else if (mv_cen) tok <= {tok[LATENCY-2:0], s_valid};
      end
    end
  endgenerate

  // Buffer FSM: capture a finished vector, then walk the index on each accepted beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      for (int r = 0; r < R; r++) data_buf[r] <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (tok_tail) begin
            for (int r = 0; r < R; r++) data_buf[r] <= conv(mv_y[r]);
            idx_q   <= '0;
            m_valid <= 1'b1;
            m_last  <= (R == 1);
            state_q <= SEND;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (m_last) begin
              // Buffer frees next cycle; no same-cycle recapture.
              state_q <= EMPTY;
              idx_q   <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              idx_q  <= idx_nxt;
              m_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_stream_tx.sv
// Bench for matvec_stream_tx: default instance fed by a 4-stage multiplier stand-in,
// plus an R=1 / LATENCY=1 instance. Inputs change on the falling edge, outputs are
// sampled on the falling edge before the inputs are updated.
module tb_matvec_stream_tx;

  typedef logic [7:0][18:0] vec_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [2:0]  i;
    logic        l;
    logic        rdy;
    logic        cen;
    logic        tail;
  } snap_t;

  logic        clk;
  logic        rstn;
  logic        s_valid, s_ready, mv_cen;
  vec_t        mv_y;
  logic [15:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic [2:0]  m_index;

  logic             s_valid1, s_ready1, mv_cen1;
  logic [0:0][18:0] mv_y1;
  logic [15:0]      m_data1;
  logic             m_valid1, m_ready1, m_last1;
  logic [0:0]       m_index1;

  vec_t       op_vec;
  vec_t       pipe [4];
  logic [3:0] pv;
  snap_t      lg [$];

  int n_cmp;
  int n_fail;

  matvec_stream_tx dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .mv_cen(mv_cen),
    .mv_y(mv_y), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_index(m_index)
  );

  matvec_stream_tx #(.R(1), .W_Y(19), .LATENCY(1), .W_O(16)) dut1 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid1), .s_ready(s_ready1), .mv_cen(mv_cen1),
    .mv_y(mv_y1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .m_last(m_last1), .m_index(m_index1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stand-in: fixed 4-stage pipeline advancing only when enabled.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
    end else if (mv_cen) begin
      pv      <= {pv[2:0], s_valid};
      pipe[0] <= op_vec;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
  end
  assign mv_y = pipe[3];

  function automatic vec_t mkvec(input int base);
    vec_t v;
    for (int r = 0; r < 8; r++) v[r] = 19'(base + r);
    return v;
  endfunction

  task automatic step(input logic sv, input vec_t vec, input logic rdy);
    snap_t s;
    @(negedge clk);
    s.v    = m_valid;
    s.d    = m_data;
    s.i    = m_index;
    s.l    = m_last;
    s.cen  = mv_cen;
    s.tail = pv[3];
    s_valid = sv;
    op_vec  = vec;
    m_ready = rdy;
    s.rdy   = rdy;
    lg.push_back(s);
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 16'd0) begin n_fail++; $display("FAIL rst_m_data: got %0d want 0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    n_cmp++; if (m_index !== 3'd0) begin n_fail++; $display("FAIL rst_m_index: got %0d want 0", m_index); end
    n_cmp++; if (mv_cen !== 1'b1) begin n_fail++; $display("FAIL rst_mv_cen: got %b want 1", mv_cen); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single;
    int k;
    lg.delete();
    step(1'b1, mkvec(1), 1'b1);
    repeat (14) step(1'b0, '0, 1'b1);
    n_cmp++; if (lg[4].v !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", lg[4].v); end
    n_cmp++; if (lg[5].v !== 1'b1) begin n_fail++; $display("FAIL single_valid_rise: got %b want 1", lg[5].v); end
    k = 0;
    for (int j = 0; j < lg.size(); j++) begin
      if (lg[j].v && lg[j].rdy) begin
        n_cmp++; if (lg[j].d !== 16'(k + 1)) begin n_fail++; $display("FAIL single_data[%0d]: got %0d want %0d", k, lg[j].d, k + 1); end
        n_cmp++; if (lg[j].i !== 3'(k)) begin n_fail++; $display("FAIL single_index[%0d]: got %0d want %0d", k, lg[j].i, k); end
        n_cmp++; if (lg[j].l !== (k == 7)) begin n_fail++; $display("FAIL single_last[%0d]: got %b want %b", k, lg[j].l, k == 7); end
        n_cmp++; if (j !== 5 + k) begin n_fail++; $display("FAIL single_slot[%0d]: got cycle %0d want %0d", k, j, 5 + k); end
        k++;
      end
    end
    n_cmp++; if (k !== 8) begin n_fail++; $display("FAIL single_count: got %0d want 8", k); end
    n_cmp++; if (lg[13].v !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got %b want 0", lg[13].v); end
  endtask

  task automatic test_back_to_back;
    int k;
    lg.delete();
    step(1'b1, mkvec(11), 1'b1);
    step(1'b1, mkvec(21), 1'b1);
    step(1'b1, mkvec(31), 1'b1);
    repeat (34) step(1'b0, '0, 1'b1);
    n_cmp++; if (lg[5].cen !== 1'b0) begin n_fail++; $display("FAIL b2b_cen_stall: got %b want 0", lg[5].cen); end
    k = 0;
    for (int j = 0; j < lg.size(); j++) begin
      if (lg[j].v && lg[j].rdy) begin
        n_cmp++; if (lg[j].d !== 16'((k / 8) * 10 + 11 + (k % 8))) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", k, lg[j].d, (k / 8) * 10 + 11 + (k % 8)); end
        n_cmp++; if (lg[j].i !== 3'(k % 8)) begin n_fail++; $display("FAIL b2b_index[%0d]: got %0d want %0d", k, lg[j].i, k % 8); end
        n_cmp++; if (lg[j].l !== ((k % 8) == 7)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b want %b", k, lg[j].l, (k % 8) == 7); end
        n_cmp++; if (j !== 5 + k + k / 8) begin n_fail++; $display("FAIL b2b_slot[%0d]: got cycle %0d want %0d", k, j, 5 + k + k / 8); end
        k++;
      end
    end
    n_cmp++; if (k !== 24) begin n_fail++; $display("FAIL b2b_count: got %0d want 24", k); end
    n_cmp++; if (lg[lg.size() - 1].v !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", lg[lg.size() - 1].v); end
  endtask

  task automatic test_backpressure;
    int k;
    int stalls;
    lg.delete();
    step(1'b1, mkvec(101), 1'b1);
    step(1'b1, mkvec(201), 1'b0);
    for (int t = 2; t < 72; t++) step(1'b0, '0, ((t % 4) == 0) || ((t % 4) == 3));
    k = 0;
    stalls = 0;
    for (int j = 0; j < lg.size(); j++) begin
      if (j > 0 && lg[j-1].v && !lg[j-1].rdy) begin
        n_cmp++;
        if ({lg[j].v, lg[j].d, lg[j].i, lg[j].l} !== {1'b1, lg[j-1].d, lg[j-1].i, lg[j-1].l}) begin
          n_fail++; $display("FAIL bp_hold@%0d: got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                             j, lg[j].v, lg[j].d, lg[j].i, lg[j].l, lg[j-1].d, lg[j-1].i, lg[j-1].l);
        end
      end
      if (lg[j].tail && lg[j].v) begin
        stalls++;
        n_cmp++; if (lg[j].cen !== 1'b0) begin n_fail++; $display("FAIL bp_cen@%0d: got %b want 0", j, lg[j].cen); end
      end
      if (lg[j].v && lg[j].rdy) begin
        n_cmp++; if (lg[j].d !== 16'((k / 8) * 100 + 101 + (k % 8))) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, lg[j].d, (k / 8) * 100 + 101 + (k % 8)); end
        n_cmp++; if (lg[j].i !== 3'(k % 8)) begin n_fail++; $display("FAIL bp_index[%0d]: got %0d want %0d", k, lg[j].i, k % 8); end
        n_cmp++; if (lg[j].l !== ((k % 8) == 7)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", k, lg[j].l, (k % 8) == 7); end
        k++;
      end
    end
    n_cmp++; if (k !== 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", k); end
    n_cmp++; if (stalls <= 0) begin n_fail++; $display("FAIL bp_stall_seen: got %0d want >0", stalls); end
  endtask

  task automatic test_width;
    vec_t v;
    logic [15:0] exp_w [6];
    int k;
    v = '0;
    v[0] = 19'(40000);
    v[1] = 19'(-40000);
    v[2] = 19'(32767);
    v[3] = 19'(32768);
    v[4] = 19'(-32768);
    v[5] = 19'(-32769);
`ifdef MATVEC_TX_SAT_EN
    exp_w[0] = 16'h7FFF; exp_w[1] = 16'h8000; exp_w[2] = 16'h7FFF;
    exp_w[3] = 16'h7FFF; exp_w[4] = 16'h8000; exp_w[5] = 16'h8000;
`else
    exp_w[0] = 16'h9C40; exp_w[1] = 16'h63C0; exp_w[2] = 16'h7FFF;
    exp_w[3] = 16'h8000; exp_w[4] = 16'h8000; exp_w[5] = 16'h7FFF;
`endif
    lg.delete();
    step(1'b1, v, 1'b1);
    repeat (14) step(1'b0, '0, 1'b1);
    k = 0;
    for (int j = 0; j < lg.size(); j++) begin
      if (lg[j].v && lg[j].rdy) begin
        if (k < 6) begin
          n_cmp++; if (lg[j].d !== exp_w[k]) begin n_fail++; $display("FAIL width[%0d]: got %0d want %0d", k, $signed(lg[j].d), $signed(exp_w[k])); end
        end
        k++;
      end
    end
    n_cmp++; if (k !== 8) begin n_fail++; $display("FAIL width_count: got %0d want 8", k); end
  endtask

  task automatic test_reset_mid;
    int nb;
    int stale;
    int k;
    lg.delete();
    step(1'b1, mkvec(51), 1'b1);
    nb = 0;
    for (int t = 0; t < 20 && nb < 3; t++) begin
      step(1'b0, '0, 1'b1);
      if (lg[lg.size() - 1].v && lg[lg.size() - 1].rdy) nb++;
    end
    n_cmp++; if (nb !== 3) begin n_fail++; $display("FAIL rmid_reach_beat3: got %0d want 3", nb); end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 16'd0) begin n_fail++; $display("FAIL rmid_m_data: got %0d want 0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rmid_m_last: got %b want 0", m_last); end
    n_cmp++; if (m_index !== 3'd0) begin n_fail++; $display("FAIL rmid_m_index: got %0d want 0", m_index); end
    n_cmp++; if (mv_cen !== 1'b1) begin n_fail++; $display("FAIL rmid_mv_cen: got %b want 1", mv_cen); end
    @(negedge clk);
    rstn = 1'b1;
    lg.delete();
    repeat (12) step(1'b0, '0, 1'b1);
    stale = 0;
    foreach (lg[j]) if (lg[j].v !== 1'b0) stale++;
    n_cmp++; if (stale !== 0) begin n_fail++; $display("FAIL rmid_stale_beats: got %0d want 0", stale); end
    lg.delete();
    step(1'b1, mkvec(61), 1'b1);
    repeat (14) step(1'b0, '0, 1'b1);
    k = 0;
    for (int j = 0; j < lg.size(); j++) begin
      if (lg[j].v && lg[j].rdy) begin
        if (k == 0) begin
          n_cmp++; if ({lg[j].d, lg[j].i} !== {16'd61, 3'd0}) begin n_fail++; $display("FAIL rmid_fresh_first: got d=%0d i=%0d want d=61 i=0", lg[j].d, lg[j].i); end
        end
        k++;
      end
    end
    n_cmp++; if (k !== 8) begin n_fail++; $display("FAIL rmid_fresh_count: got %0d want 8", k); end
  endtask

  task automatic test_r1;
    mv_y1[0] = 19'd77;
    @(negedge clk);
    s_valid1 = 1'b1;
    @(negedge clk);
    s_valid1 = 1'b0;
    n_cmp++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL r1_early: got %b want 0", m_valid1); end
    @(negedge clk);
    n_cmp++; if (m_valid1 !== 1'b1) begin n_fail++; $display("FAIL r1_valid: got %b want 1", m_valid1); end
    n_cmp++; if (m_data1 !== 16'd77) begin n_fail++; $display("FAIL r1_data: got %0d want 77", m_data1); end
    n_cmp++; if (m_last1 !== 1'b1) begin n_fail++; $display("FAIL r1_last: got %b want 1", m_last1); end
    n_cmp++; if (m_index1 !== 1'b0) begin n_fail++; $display("FAIL r1_index: got %0d want 0", m_index1); end
    @(negedge clk);
    n_cmp++; if (m_valid1 !== 1'b0) begin n_fail++; $display("FAIL r1_single_beat: got %b want 0", m_valid1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    op_vec   = '0;
    m_ready  = 1'b0;
    s_valid1 = 1'b0;
    m_ready1 = 1'b1;
    mv_y1    = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_width();
    test_reset_mid();
    test_r1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
